// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared FSM state encoding and limits for the Montgomery FIOS core
package mont_pkg;

  localparam int MONT_MAX_N = 64;

  typedef enum logic [2:0] {
    IDLE,
    ROW_FETCH,
    ROW_MAC,
    ROW_TOP,
    SUB_FETCH,
    SUB,
    OUT,
    DONE
  } mont_state_e;

endpackage

// File: rtl/mont_word_mac.sv
// rtl/mont_word_mac.sv - combinational word step t + a*b + q*m + c, 2K+1-bit result
module mont_word_mac #(
  parameter int K = 64
) (
  input  logic [K-1:0] t,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] q,
  input  logic [K-1:0] m,
  input  logic [K:0]   c,
  output logic [2*K:0] sum
);

  // Worst case is 2^(2K+1) - 2^K, so 2K+1 bits never overflow.
  assign sum = (2*K+1)'(t)
             + (2*K+1)'(a) * (2*K+1)'(b)
             + (2*K+1)'(q) * (2*K+1)'(m)
             + (2*K+1)'(c);

endmodule

// File: rtl/mont_fios_core.sv
// rtl/mont_fios_core.sv - word-serial FIOS Montgomery multiplier, Z = X*Y*R^-1 mod M
module mont_fios_core
  import mont_pkg::*;
#(
  parameter int K      = 64,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K-1:0]      m_inv,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] y_addr,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [K-1:0]      x_data,
  input  logic [K-1:0]      y_data,
  input  logic [K-1:0]      m_data,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [K-1:0]      res_data,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  mont_state_e       state, state_nxt;
  logic [ADDR_W-1:0] row, col, col_nxt;
  logic [K-1:0]      t_mem [N];
  logic [K-1:0]      d_mem [N];
  logic              t_top;
  logic [K:0]        carry;
  logic              borrow, use_d;
  logic [K-1:0]      m_inv_q, q_reg;
  logic [K-1:0]      t0_xy, q_comb, q_use;
  logic [2*K:0]      mac_sum;
  logic [K:0]        top_sum, sub_diff;

  assign col_nxt  = col + 1'b1;
  assign t0_xy    = t_mem[0] + x_data * y_data;
  assign q_comb   = t0_xy * m_inv_q;
  assign q_use    = (col == '0) ? q_comb : q_reg;
  assign top_sum  = carry + (K+1)'(t_top);
  assign sub_diff = {1'b0, t_mem[col]} - {1'b0, m_data} - (K+1)'(borrow);

  mont_word_mac #(.K(K)) u_mac (
    .t   (t_mem[col]),
    .a   (x_data),
    .b   (y_data),
    .q   (q_use),
    .m   (m_data),
    .c   (carry),
    .sum (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read addresses run one word ahead because memory data arrives a cycle late.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    res_valid = (state == OUT);
    res_addr  = '0;
    res_data  = '0;
    x_addr    = '0;
    y_addr    = '0;
    m_addr    = '0;
    case (state)
      IDLE:      if (start) state_nxt = ROW_FETCH;
      ROW_FETCH: begin
        x_addr    = row;
        state_nxt = ROW_MAC;
      end
      ROW_MAC: begin
        x_addr = row;
        y_addr = col_nxt;
        m_addr = col_nxt;
        if (col == LAST) state_nxt = ROW_TOP;
      end
      ROW_TOP:   state_nxt = (row == LAST) ? SUB_FETCH : ROW_FETCH;
      SUB_FETCH: state_nxt = SUB;
      SUB: begin
        m_addr = col_nxt;
        if (col == LAST) state_nxt = OUT;
      end
      OUT: begin
        res_addr = col;
        res_data = use_d ? d_mem[col] : t_mem[col];
        if (res_ready && col == LAST) state_nxt = DONE;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      carry   <= '0;
      t_top   <= 1'b0;
      borrow  <= 1'b0;
      use_d   <= 1'b0;
      m_inv_q <= '0;
      q_reg   <= '0;
      for (int n = 0; n < N; n++) begin
        t_mem[n] <= '0;
        d_mem[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          m_inv_q <= m_inv;
          row     <= '0;
          col     <= '0;
          carry   <= '0;
          t_top   <= 1'b0;
          for (int n = 0; n < N; n++) t_mem[n] <= '0;
        end
        ROW_MAC: begin
          if (col == '0) q_reg <= q_comb;
          else           t_mem[col - 1'b1] <= mac_sum[K-1:0];
          carry <= mac_sum[2*K:K];
          col   <= (col == LAST) ? '0 : col_nxt;
        end
        ROW_TOP: begin
          t_mem[N-1] <= top_sum[K-1:0];
          t_top      <= top_sum[K];
          carry      <= '0;
          row        <= (row == LAST) ? '0 : row + 1'b1;
        end
        SUB_FETCH: begin
          borrow <= 1'b0;
          col    <= '0;
        end
        SUB: begin
          d_mem[col] <= sub_diff[K-1:0];
          borrow     <= sub_diff[K];
          if (col == LAST) begin
            use_d <= t_top | ~sub_diff[K];
            col   <= '0;
          end else begin
            col <= col_nxt;
          end
        end
        OUT: if (res_ready) col <= (col == LAST) ? '0 : col_nxt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_fios_core.sv
// tb/tb_mont_fios_core.sv - directed bench for mont_fios_core with K=8, N=2, M=0xFFF1
module tb_mont_fios_core;

  localparam int K = 8;
  localparam int N = 2;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [K-1:0]  m_inv = 8'hEF;
  logic [AW-1:0] x_addr, y_addr, m_addr, res_addr;
  logic [K-1:0]  x_data = '0, y_data = '0, m_data = '0, res_data;
  logic          busy, res_valid, done;
  logic          res_ready = 1'b1;
  logic [15:0]   xv = '0, yv = '0, mv = 16'hFFF1;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_data <= xv[int'(x_addr)*8 +: 8];
    y_data <= yv[int'(y_addr)*8 +: 8];
    m_data <= mv[int'(m_addr)*8 +: 8];
  end

  mont_fios_core #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .m_inv     (m_inv),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .m_addr    (m_addr),
    .x_data    (x_data),
    .y_data    (y_data),
    .m_data    (m_data),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .done      (done)
  );

  // Cycle 1 is the period right after the start-accept edge.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int stall,
                        input int restart_cyc, input int rst_cyc,
                        output logic [15:0] res, output int done_cyc, output int ndone,
                        output int hs_at_done, output logic [7:0] held, output bit stable_ok,
                        output bit busy1, output bit busy_rst);
    int left, nhs;
    xv = x; yv = y; res = '0; done_cyc = -1; ndone = 0; hs_at_done = -1;
    held = '0; stable_ok = 1'b1; busy1 = 1'b0; busy_rst = 1'b1; left = stall; nhs = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 1) busy1 = busy;
      start = (cyc == restart_cyc);
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1 busy_rst = busy;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          hs_at_done = nhs;
        end
      end
      if (res_valid) begin
        if (left > 0 && res_addr == 1'b0) begin
          if (left == stall) held = res_data;
          else if (res_data !== held) stable_ok = 1'b0;
          res_ready = 1'b0;
          left--;
        end else begin
          if (stall > 0 && res_addr == 1'b0 && res_data !== held) stable_ok = 1'b0;
          res_ready = 1'b1;
          res[int'(res_addr)*8 +: 8] = res_data;
          nhs++;
        end
      end else begin
        res_ready = 1'b1;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    total++; if (res_data !== 8'h00) begin bad++; $display("FAIL reset_res_data: got %h want 00", res_data); end
    total++; if ({x_addr, y_addr, m_addr, res_addr} !== 4'b0000)
      begin bad++; $display("FAIL reset_addrs: got %b want 0000", {x_addr, y_addr, m_addr, res_addr}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    logic [15:0] res; logic [7:0] held; int dc, nd, hs; bit st, b1, br;
    run_op(16'h000F, 16'h1234, 0, 0, 0, res, dc, nd, hs, held, st, b1, br);
    total++; if (res !== 16'h1234) begin bad++; $display("FAIL basic_result: got %h want 1234", res); end
    total++; if (dc !== 14) begin bad++; $display("FAIL basic_done_cycle: got %0d want 14", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy_cycle1: got %b want 1", b1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_sub_boundary;
    logic [15:0] res; logic [7:0] held; int dc, nd, hs; bit st, b1, br;
    run_op(16'h000F, 16'hFFF0, 0, 0, 0, res, dc, nd, hs, held, st, b1, br);
    total++; if (res !== 16'hFFF0) begin bad++; $display("FAIL sub_result: got %h want fff0", res); end
    total++; if (dc !== 14) begin bad++; $display("FAIL sub_done_cycle: got %0d want 14", dc); end
  endtask

  task automatic test_zero;
    logic [15:0] res; logic [7:0] held; int dc, nd, hs; bit st, b1, br;
    run_op(16'h0000, 16'hABCD, 0, 0, 0, res, dc, nd, hs, held, st, b1, br);
    total++; if (res !== 16'h0000) begin bad++; $display("FAIL zero_result: got %h want 0000", res); end
  endtask

  task automatic test_stall;
    logic [15:0] res; logic [7:0] held; int dc, nd, hs; bit st, b1, br;
    run_op(16'h000F, 16'h1234, 5, 0, 0, res, dc, nd, hs, held, st, b1, br);
    total++; if (held !== 8'h34) begin bad++; $display("FAIL stall_held_word: got %h want 34", held); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_stable: got %b want 1", st); end
    total++; if (res !== 16'h1234) begin bad++; $display("FAIL stall_result: got %h want 1234", res); end
    total++; if (dc !== 19) begin bad++; $display("FAIL stall_done_cycle: got %0d want 19", dc); end
    total++; if (hs !== 2) begin bad++; $display("FAIL stall_hs_before_done: got %0d want 2", hs); end
    total++; if (nd !== 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] res; logic [7:0] held; int dc, nd, hs; bit st, b1, br;
    run_op(16'h000F, 16'h1234, 0, 3, 0, res, dc, nd, hs, held, st, b1, br);
    total++; if (res !== 16'h1234) begin bad++; $display("FAIL restart_result: got %h want 1234", res); end
    total++; if (dc !== 14) begin bad++; $display("FAIL restart_done_cycle: got %0d want 14", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] res; logic [7:0] held; int dc, nd, hs, late; bit st, b1, br;
    run_op(16'h000F, 16'h1234, 0, 0, 6, res, dc, nd, hs, held, st, b1, br);
    total++; if (br !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", br); end
    late = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) late++;
      @(negedge clk);
    end
    total++; if (late !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", late); end
    run_op(16'h000F, 16'h1234, 0, 0, 0, res, dc, nd, hs, held, st, b1, br);
    total++; if (res !== 16'h1234) begin bad++; $display("FAIL abort_rerun_result: got %h want 1234", res); end
    total++; if (dc !== 14) begin bad++; $display("FAIL abort_rerun_done_cycle: got %0d want 14", dc); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sub_boundary;
    test_zero;
    test_stall;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mont_fios_core.md
MONT_FIOS_CORE -- requirements
Module: mont_fios_core

Interface
REQ-001 SHALL have parameter K, default 64: word width in bits (legal 8..256).
REQ-002 SHALL have parameter N, default 32: operand length in words (legal 2..64).
REQ-003 SHALL have parameter ADDR_W, default $clog2(N): word address width.
REQ-004 SHALL have port clk, input, 1: clock, all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin an operation; honoured only in IDLE.
REQ-007 SHALL have port m_inv, input, K: -M^-1 mod 2^K, sampled on accepted start.
REQ-008 SHALL have ports x_addr, y_addr and m_addr, output, ADDR_W each: read addresses for X, Y and M.
REQ-009 SHALL have ports x_data, y_data and m_data, input, K each: read data, valid the cycle after the address.
REQ-010 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_addr (output, ADDR_W) and res_data (output, K): result word stream, LSW first.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the last result handshake.

Function
REQ-013 SHALL compute Z = X*Y*2^(-K*N) mod M, with 0 <= Z < M, for odd M and X, Y < M.
REQ-014 SHALL use the FIOS word-serial algorithm with scratch T of N+1 words, cleared on accepted start.
REQ-015 SHALL use FSM states IDLE -> ROW_FETCH -> ROW_MAC -> ROW_TOP, repeated N times, then SUB_FETCH -> SUB -> OUT -> DONE -> IDLE.
REQ-016 SHALL, in ROW_FETCH for row i, issue x_addr=i, y_addr=0 and m_addr=0 (1 cycle).
REQ-017 SHALL, in ROW_MAC at j=0, compute q = ((T0 + x_i*y_0) * m_inv) mod 2^K and hold q for the row.
REQ-018 SHALL, in ROW_MAC for each j=0..N-1, form (C, w) = T[j] + x_i*y_j + q*m_j + C, write T[j-1]=w for j>0, and discard w at j=0 (always zero); one word per cycle, N cycles.
REQ-019 SHALL keep carry C at K+1 bits with no overflow.
REQ-020 SHALL, in ROW_TOP, set (T[N], T[N-1]) = T[N] + C and clear C (1 cycle).
REQ-021 SHALL, in SUB, compute D = T - M word-serially with a borrow chain and store D in a second N-word buffer (1 fetch cycle + N cycles).
REQ-022 SHALL select D when T[N]=1 or the final borrow=0, else T.
REQ-023 SHALL, in OUT, present word k on res_data/res_addr=k with res_valid high and advance only on res_valid & res_ready.
REQ-024 SHALL hold res_data and res_addr stable while res_ready is low.
REQ-025 SHALL, with res_ready held high, assert done exactly N*(N+2) + (N+1) + N + 1 cycles after the start-accept edge.
REQ-026 SHALL ignore start while busy; start and done in the same cycle SHALL NOT begin a new operation (the new operation starts from IDLE on a later start).
REQ-027 SHALL take m_inv and M from inputs only; X, Y and M SHALL NOT change while busy (caller responsibility, not checked).

Reset
REQ-028 SHALL, when rst_n is low, force busy=0, done=0, res_valid=0, res_addr=0, res_data=0, all read addresses 0, FSM=IDLE, C=0, T cleared.
REQ-029 SHALL, on reset asserted mid-operation, abort immediately with no done pulse; the first start after release SHALL run a full operation.

Structure
REQ-030 SHALL place the FSM state enum and a MONT_MAX_N constant in shared package mont_pkg.
REQ-031 SHALL implement the word datapath T + a*b + q*m + c (K-bit operands, 2K+1-bit result) as sub-module mont_word_mac, combinational, instantiated once.

Verification (K=8, N=2, M=0xFFF1, m_inv=0xEF, R mod M=0x000F)
REQ-032 SHALL verify X=0x000F, Y=0x1234 -> res words 0x34, 0x12; done at cycle 2*4+3+2+1=14.
REQ-033 SHALL verify X=0x000F, Y=0xFFF0 -> result 0xFFF0, which checks the final-subtract boundary.
REQ-034 SHALL verify X=0x0000, Y=0xABCD -> result 0x0000.
REQ-035 SHALL verify res_ready low for 5 cycles during OUT word 0 -> res_data=0x34 held stable, no done until both handshakes, done delayed by 5 cycles.
REQ-036 SHALL verify a second start at cycle 3 of busy -> ignored, single done, result unchanged.
REQ-037 SHALL verify rst_n pulsed low at cycle 6, then a fresh start with X=0x000F, Y=0x1234 -> busy=0 at once, no done from the aborted run, correct 0x1234 from the new run.
